subpel_block_sequencer: RTL and testbench
=========================================

SUBPEL_BLOCK_SEQUENCER -- requirements
Module: subpel_block_sequencer

Interface
REQ-001 Parameter BLK, 8, block edge in pixels.
REQ-002 Parameter ROWS, 15, reference rows fetched per block (BLK + 7 filter-tap rows).
REQ-003 Parameter PAD_PRE, 3, rows fetched above the block.
REQ-004 clk  in  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  one-cycle request to process a frame.
REQ-007 frame_w_blk  in  4  frame width in blocks.
REQ-008 frame_h_blk  in  4  frame height in blocks.
REQ-009 busy  out  1  high from accepted start until done.
REQ-010 done  out  1  one-cycle pulse when the frame is finished.
REQ-011 mem_req  out  1  row-read request.
REQ-012 mem_row  out  8  clamped pixel row address.
REQ-013 mem_col  out  9  signed column base, blk_x*BLK-3.
REQ-014 mem_ack  in  1  read accepted; mem_data valid this cycle.
REQ-015 mem_data  in  120  15 packed 8-bit pixels.
REQ-016 core_start  out  1  one-cycle pulse that starts the interpolation core for a block.
REQ-017 core_row  out  120  registered copy of mem_data.
REQ-018 core_row_vld  out  1  core_row valid for one cycle.
REQ-019 core_row_idx  out  4  row index, 0..14.
REQ-020 core_done  in  1  core has finished the current block.
REQ-021 blk_x, blk_y  out  4 each  current block coordinates.
REQ-022 blk_vld  out  1  core outputs A/B/C are valid for (blk_x, blk_y).
REQ-023 blk_ack  in  1  consumer has taken the block.

Function
REQ-024 The FSM SHALL have the states IDLE, FETCH, WAIT_CORE, OUTPUT.
REQ-025 IDLE behaviour: start with both dimensions nonzero SHALL latch the dimensions, clear blk_x/blk_y, pulse core_start, and enter FETCH.
REQ-026 IDLE behaviour: start with either dimension zero SHALL pulse done on the next cycle, with no fetch and busy held low.
REQ-027 start SHALL be ignored outside IDLE.
REQ-028 FETCH: mem_req SHALL be held high and mem_row/mem_col held stable until mem_ack; the row counter r SHALL start at 0.
REQ-029 FETCH: on mem_ack, the cycle after SHALL show core_row=mem_data, core_row_vld=1 and core_row_idx=r; r then increments.
REQ-030 FETCH: mem_req SHALL deassert for at least one cycle after each ack.
REQ-031 FETCH: the ack with r=14 SHALL move the FSM to WAIT_CORE.
REQ-032 Row address rule: mem_row = clamp(blk_y*BLK + r - PAD_PRE, 0, frame_h_blk*BLK-1), computed in signed 9-bit arithmetic.
REQ-033 WAIT_CORE: core_done SHALL move the FSM to OUTPUT, with blk_vld=1 from the next cycle; core_done SHALL be ignored in every other state.
REQ-034 OUTPUT: blk_vld and blk_x/blk_y SHALL hold until blk_ack.
REQ-035 OUTPUT, on blk_ack: advance in raster order (x+1; at x=frame_w_blk-1, wrap x to 0 and increment y), pulse core_start, and re-enter FETCH.
REQ-036 OUTPUT, last block: blk_ack on the last block SHALL pulse done, drop busy and blk_vld in the same cycle, and return to IDLE.
REQ-037 Coincident acks: mem_ack and blk_ack are never both relevant in one state; an ack outside its state SHALL be ignored.
REQ-038 busy SHALL be 1 in FETCH, WAIT_CORE and OUTPUT.

Reset
REQ-039 rst SHALL force IDLE and zero every output and counter on the next edge, including mid-fetch or mid-OUTPUT.
REQ-040 Frame processing SHALL resume only on a new start after rst is released.

Structure
REQ-041 The package subpel_pkg SHALL hold the state enum, BLK, ROWS and PAD_PRE.
REQ-042 The single sub-module subpel_addr_gen SHALL contain the mem_row clamp and the mem_col computation.

Verification
REQ-043 Frame 1x1, mem_ack always high: mem_row sequence 0,0,0,0,1..7,7,7,7,7; core_row_idx 0..14; done after blk_ack.
REQ-044 Frame 2x2: blocks are visited (0,0),(1,0),(0,1),(1,1); at blk_y=1, mem_row runs 5..15 and then 15 four times; for blk_x=0 and blk_x=1, mem_col is -3 and 5.
REQ-045 mem_ack delayed 3 cycles per row: mem_row stays stable while waiting, and exactly 15 core_row_vld pulses occur per block.
REQ-046 rst asserted at fetch row 7: the next cycle shows IDLE, busy=0 and mem_req=0; a fresh start restarts at block (0,0), row 0.
REQ-047 start with frame_w_blk=0: done pulses next cycle, with no mem_req and no core_start.
REQ-048 start pulsed while busy, plus a stray core_done during FETCH: no effect on the block sequence.

Source files
------------

// File: rtl/subpel_block_sequencer_pkg.sv
// Shared constants and FSM state encoding for the sub-pel block sequencer.
package subpel_pkg;

  localparam int unsigned BLK     = 8;   // block edge in pixels
  localparam int unsigned ROWS    = 15;  // BLK + 7 filter-tap rows
  localparam int unsigned PAD_PRE = 3;   // rows/columns fetched before the block
  localparam int unsigned PIX_W   = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FETCH     = 2'd1,
    WAIT_CORE = 2'd2,
    OUTPUT    = 2'd3
  } state_e;

endpackage

// File: rtl/subpel_block_sequencer_if.sv
// Reference-memory row-read port: request with address, ack with a packed pixel row.
interface subpel_block_sequencer_if #(
  parameter int unsigned DATA_W = 120
);

  logic              mem_req;
  logic [7:0]        mem_row;
  logic [8:0]        mem_col;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_data;

  modport master (
    output mem_req,
    output mem_row,
    output mem_col,
    input  mem_ack,
    input  mem_data
  );

  modport slave (
    input  mem_req,
    input  mem_row,
    input  mem_col,
    output mem_ack,
    output mem_data
  );

endinterface

// File: rtl/subpel_block_sequencer_addr_gen.sv
// Row/column address generation: vertical clamp to the frame, signed column base.
module subpel_addr_gen #(
  parameter int unsigned BLK     = 8,
  parameter int unsigned PAD_PRE = 3
) (
  input  logic [3:0] blk_x,
  input  logic [3:0] blk_y,
  input  logic [3:0] row_idx,
  input  logic [3:0] frame_h_blk,
  output logic [7:0] mem_row,
  output logic [8:0] mem_col
);

  logic signed [8:0] row_s;
  logic signed [8:0] max_s;

  // Arithmetic wraps modulo 2^9, so the truncating casts yield the signed 9-bit result.
  always_comb begin
    row_s   = 9'(int'(blk_y) * BLK + int'(row_idx) - PAD_PRE);
    max_s   = 9'(int'(frame_h_blk) * BLK - 1);
    mem_col = 9'(int'(blk_x) * BLK - PAD_PRE);
    if (row_s < 9'sd0) begin
      mem_row = '0;
    end else if (row_s > max_s) begin
      mem_row = max_s[7:0];
    end else begin
      mem_row = row_s[7:0];
    end
  end

endmodule

// File: rtl/subpel_block_sequencer.sv
// Walks a frame block by block in raster order, fetching ROWS reference rows per
// block, handing them to the interpolation core and presenting each finished block.
module subpel_block_sequencer #(
  parameter int unsigned BLK     = 8,
  parameter int unsigned ROWS    = 15,
  parameter int unsigned PAD_PRE = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [3:0]             frame_w_blk,
  input  logic [3:0]             frame_h_blk,
  output logic                   busy,
  output logic                   done,
  subpel_block_sequencer_if.master mem,
  output logic                   core_start,
  output logic [ROWS*8-1:0]      core_row,
  output logic                   core_row_vld,
  output logic [3:0]             core_row_idx,
  input  logic                   core_done,
  output logic [3:0]             blk_x,
  output logic [3:0]             blk_y,
  output logic                   blk_vld,
  input  logic                   blk_ack
);

  import subpel_pkg::*;

  state_e            state_q, state_d;
  logic [3:0]        w_q, w_d;
  logic [3:0]        h_q, h_d;
  logic [3:0]        blk_x_q, blk_x_d;
  logic [3:0]        blk_y_q, blk_y_d;
  logic [3:0]        r_q, r_d;
  logic              mem_req_q, mem_req_d;
  logic              core_start_q, core_start_d;
  logic [ROWS*8-1:0] core_row_q, core_row_d;
  logic              core_row_vld_q, core_row_vld_d;
  logic [3:0]        core_row_idx_q, core_row_idx_d;
  logic              blk_vld_q, blk_vld_d;
  logic              done_q, done_d;

  logic [7:0]        row_ag;
  logic [8:0]        col_ag;
  logic              last_blk;

  subpel_addr_gen #(
    .BLK     (BLK),
    .PAD_PRE (PAD_PRE)
  ) u_addr_gen (
    .blk_x       (blk_x_q),
    .blk_y       (blk_y_q),
    .row_idx     (r_q),
    .frame_h_blk (h_q),
    .mem_row     (row_ag),
    .mem_col     (col_ag)
  );

  assign last_blk = (blk_x_q == w_q - 4'd1) && (blk_y_q == h_q - 4'd1);

  always_comb begin
    state_d        = state_q;
    w_d            = w_q;
    h_d            = h_q;
    blk_x_d        = blk_x_q;
    blk_y_d        = blk_y_q;
    r_d            = r_q;
    mem_req_d      = 1'b0;
    core_start_d   = 1'b0;
    core_row_d     = core_row_q;
    core_row_vld_d = 1'b0;
    core_row_idx_d = core_row_idx_q;
    blk_vld_d      = blk_vld_q;
    done_d         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (frame_w_blk != 4'd0 && frame_h_blk != 4'd0) begin
            w_d          = frame_w_blk;
            h_d          = frame_h_blk;
            blk_x_d      = '0;
            blk_y_d      = '0;
            r_d          = '0;
            core_start_d = 1'b1;
            mem_req_d    = 1'b1;
            state_d      = FETCH;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      // The request drops for the cycle after each accepted row.
      FETCH: begin
        mem_req_d = 1'b1;
        if (mem_req_q && mem.mem_ack) begin
          mem_req_d      = 1'b0;
          core_row_d     = mem.mem_data;
          core_row_vld_d = 1'b1;
          core_row_idx_d = r_q;
          if (r_q == 4'(ROWS - 1)) begin
            r_d     = '0;
            state_d = WAIT_CORE;
          end else begin
            r_d = r_q + 4'd1;
          end
        end
      end

      WAIT_CORE: begin
        if (core_done) begin
          blk_vld_d = 1'b1;
          state_d   = OUTPUT;
        end
      end

      OUTPUT: begin
        if (blk_ack) begin
          blk_vld_d = 1'b0;
          if (last_blk) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            if (blk_x_q == w_q - 4'd1) begin
              blk_x_d = '0;
              blk_y_d = blk_y_q + 4'd1;
            end else begin
              blk_x_d = blk_x_q + 4'd1;
            end
            core_start_d = 1'b1;
            mem_req_d    = 1'b1;
            state_d      = FETCH;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      w_q            <= '0;
      h_q            <= '0;
      blk_x_q        <= '0;
      blk_y_q        <= '0;
      r_q            <= '0;
      mem_req_q      <= 1'b0;
      core_start_q   <= 1'b0;
      core_row_q     <= '0;
      core_row_vld_q <= 1'b0;
      core_row_idx_q <= '0;
      blk_vld_q      <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      w_q            <= w_d;
      h_q            <= h_d;
      blk_x_q        <= blk_x_d;
      blk_y_q        <= blk_y_d;
      r_q            <= r_d;
      mem_req_q      <= mem_req_d;
      core_start_q   <= core_start_d;
      core_row_q     <= core_row_d;
      core_row_vld_q <= core_row_vld_d;
      core_row_idx_q <= core_row_idx_d;
      blk_vld_q      <= blk_vld_d;
      done_q         <= done_d;
    end
  end

  // Addresses are only driven while fetching so the idle bus reads as zero.
  assign mem.mem_req   = mem_req_q;
  assign mem.mem_row   = (state_q == FETCH) ? row_ag : '0;
  assign mem.mem_col   = (state_q == FETCH) ? col_ag : '0;

  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign core_start   = core_start_q;
  assign core_row     = core_row_q;
  assign core_row_vld = core_row_vld_q;
  assign core_row_idx = core_row_idx_q;
  assign blk_x        = blk_x_q;
  assign blk_y        = blk_y_q;
  assign blk_vld      = blk_vld_q;

endmodule

// File: tb/tb_subpel_block_sequencer.sv
// Directed bench for subpel_block_sequencer: a table of per-block vectors plus
// hand-written reset, zero-size and stray-input sequences.
module tb_subpel_block_sequencer;

  logic         clk;
  logic         rst;
  logic         start;
  logic [3:0]   frame_w_blk;
  logic [3:0]   frame_h_blk;
  logic         busy;
  logic         done;
  logic         core_start;
  logic [119:0] core_row;
  logic         core_row_vld;
  logic [3:0]   core_row_idx;
  logic         core_done;
  logic [3:0]   blk_x;
  logic [3:0]   blk_y;
  logic         blk_vld;
  logic         blk_ack;

  subpel_block_sequencer_if #(.DATA_W(120)) mem_if ();

  subpel_block_sequencer #(
    .BLK     (8),
    .ROWS    (15),
    .PAD_PRE (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .frame_w_blk  (frame_w_blk),
    .frame_h_blk  (frame_h_blk),
    .busy         (busy),
    .done         (done),
    .mem          (mem_if),
    .core_start   (core_start),
    .core_row     (core_row),
    .core_row_vld (core_row_vld),
    .core_row_idx (core_row_idx),
    .core_done    (core_done),
    .blk_x        (blk_x),
    .blk_y        (blk_y),
    .blk_vld      (blk_vld),
    .blk_ack      (blk_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  w;
    logic [3:0]  h;
    logic [3:0]  bx;
    logic [3:0]  by;
    logic [8:0]  col;
    int unsigned pat;
    int unsigned dly;
    bit          stray;
    bit          last;
  } vec_t;

  vec_t       vecs [11];
  logic [7:0] rowpat [5][15];

  int n_chk  = 0;
  int n_fail = 0;
  int vld_cnt = 0;
  int cs_cnt  = 0;

  always @(posedge clk) begin
    #1;
    if (core_row_vld) vld_cnt++;
    if (core_start)   cs_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wait_req();
    int unsigned n = 0;
    while (mem_if.mem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("mem_req_wait", 128'(mem_if.mem_req), 128'd1);
  endtask

  task automatic start_frame(input logic [3:0] w, input logic [3:0] h);
    @(negedge clk);
    frame_w_blk = w;
    frame_h_blk = h;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy",       128'(busy),        128'd1);
    chk("start_core_start", 128'(core_start),  128'd1);
    chk("start_mem_req",    128'(mem_if.mem_req), 128'd1);
    chk("start_blk_xy",     128'({blk_x, blk_y}), 128'd0);
  endtask

  task automatic run_block(input vec_t v);
    logic [119:0] data;
    int           base;
    base = vld_cnt;
    if (v.dly == 0) mem_if.mem_ack = 1'b1;
    for (int r = 0; r < 15; r++) begin
      wait_req();
      data = 120'({$urandom(), $urandom(), $urandom(), $urandom()});
      mem_if.mem_data = data;
      chk("mem_row", 128'(mem_if.mem_row), 128'(rowpat[v.pat][r]));
      chk("mem_col", 128'(mem_if.mem_col), 128'(v.col));
      if (v.dly != 0) begin
        for (int d = 0; d < int'(v.dly); d++) begin
          @(negedge clk);
          chk("req_held",   128'(mem_if.mem_req), 128'd1);
          chk("row_stable", 128'(mem_if.mem_row), 128'(rowpat[v.pat][r]));
        end
        mem_if.mem_ack = 1'b1;
      end
      if (v.stray && r == 5) begin
        start       = 1'b1;
        frame_w_blk = 4'd5;
        core_done   = 1'b1;
      end
      @(negedge clk);
      if (v.dly != 0) mem_if.mem_ack = 1'b0;
      start       = 1'b0;
      core_done   = 1'b0;
      frame_w_blk = v.w;
      chk("core_row_vld", 128'(core_row_vld), 128'd1);
      chk("core_row",     128'(core_row),     128'(data));
      chk("core_row_idx", 128'(core_row_idx), 128'(r));
      chk("req_gap",      128'(mem_if.mem_req), 128'd0);
    end
    mem_if.mem_ack = 1'b0;
    @(negedge clk);
    chk("wait_busy",    128'(busy),           128'd1);
    chk("wait_req_low", 128'(mem_if.mem_req), 128'd0);
    chk("wait_blk_vld", 128'(blk_vld),        128'd0);
    chk("vld_pulses",   128'(vld_cnt - base), 128'd15);
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    chk("blk_vld", 128'(blk_vld), 128'd1);
    chk("blk_xy",  128'({blk_x, blk_y}), 128'({v.bx, v.by}));
    repeat (2) begin
      @(negedge clk);
      chk("blk_vld_hold", 128'(blk_vld), 128'd1);
      chk("blk_xy_hold",  128'({blk_x, blk_y}), 128'({v.bx, v.by}));
    end
    blk_ack = 1'b1;
    @(negedge clk);
    blk_ack = 1'b0;
    chk("ack_blk_vld", 128'(blk_vld), 128'd0);
    if (v.last) begin
      chk("last_done", 128'(done), 128'd1);
      chk("last_busy", 128'(busy), 128'd0);
      @(negedge clk);
      chk("done_pulse", 128'(done), 128'd0);
    end else begin
      chk("next_done",       128'(done),       128'd0);
      chk("next_core_start", 128'(core_start), 128'd1);
      chk("next_busy",       128'(busy),       128'd1);
    end
  endtask

  initial begin
    rowpat[0] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7};
    rowpat[1] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10, 8'd11};
    rowpat[2] = '{8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd15, 8'd15, 8'd15, 8'd15};
    rowpat[3] = '{8'd13, 8'd14, 8'd15, 8'd16, 8'd17, 8'd18, 8'd19, 8'd20, 8'd21, 8'd22, 8'd23, 8'd23, 8'd23, 8'd23, 8'd23};
    rowpat[4] = '{8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17, 8'd18, 8'd19};

    //           w     h     bx    by    col      pat dly stray last
    vecs[0]  = '{4'd1, 4'd1, 4'd0, 4'd0, 9'h1FD, 0, 0, 1'b0, 1'b1};
    vecs[1]  = '{4'd2, 4'd2, 4'd0, 4'd0, 9'h1FD, 1, 0, 1'b0, 1'b0};
    vecs[2]  = '{4'd2, 4'd2, 4'd1, 4'd0, 9'd5,   1, 0, 1'b0, 1'b0};
    vecs[3]  = '{4'd2, 4'd2, 4'd0, 4'd1, 9'h1FD, 2, 0, 1'b0, 1'b0};
    vecs[4]  = '{4'd2, 4'd2, 4'd1, 4'd1, 9'd5,   2, 0, 1'b0, 1'b1};
    vecs[5]  = '{4'd1, 4'd3, 4'd0, 4'd0, 9'h1FD, 1, 3, 1'b1, 1'b0};
    vecs[6]  = '{4'd1, 4'd3, 4'd0, 4'd1, 9'h1FD, 4, 3, 1'b0, 1'b0};
    vecs[7]  = '{4'd1, 4'd3, 4'd0, 4'd2, 9'h1FD, 3, 3, 1'b0, 1'b1};
    vecs[8]  = '{4'd3, 4'd1, 4'd0, 4'd0, 9'h1FD, 0, 1, 1'b0, 1'b0};
    vecs[9]  = '{4'd3, 4'd1, 4'd1, 4'd0, 9'd5,   0, 1, 1'b0, 1'b0};
    vecs[10] = '{4'd3, 4'd1, 4'd2, 4'd0, 9'd13,  0, 1, 1'b1 ^ 1'b1, 1'b1};

    rst             = 1'b1;
    start           = 1'b0;
    frame_w_blk     = '0;
    frame_h_blk     = '0;
    core_done       = 1'b0;
    blk_ack         = 1'b0;
    mem_if.mem_ack  = 1'b0;
    mem_if.mem_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy",    128'(busy),           128'd0);
    chk("rst_done",    128'(done),           128'd0);
    chk("rst_mem_req", 128'(mem_if.mem_req), 128'd0);
    chk("rst_mem_row", 128'(mem_if.mem_row), 128'd0);
    chk("rst_mem_col", 128'(mem_if.mem_col), 128'd0);
    chk("rst_core",    128'({core_start, core_row_vld, core_row_idx}), 128'd0);
    chk("rst_row",     128'(core_row),       128'd0);
    chk("rst_blk",     128'({blk_x, blk_y, blk_vld}), 128'd0);
    rst = 1'b0;

    // Zero-sized frames: done next cycle, nothing fetched or started.
    frame_w_blk = 4'd0;
    frame_h_blk = 4'd2;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("zero_w_done",       128'(done),           128'd1);
    chk("zero_w_busy",       128'(busy),           128'd0);
    chk("zero_w_mem_req",    128'(mem_if.mem_req), 128'd0);
    chk("zero_w_core_start", 128'(core_start),     128'd0);
    @(negedge clk);
    chk("zero_w_done_pulse", 128'(done),           128'd0);
    chk("zero_w_idle_req",   128'(mem_if.mem_req), 128'd0);
    frame_w_blk = 4'd3;
    frame_h_blk = 4'd0;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("zero_h_done", 128'(done), 128'd1);
    chk("zero_h_busy", 128'(busy), 128'd0);

    // Reset in the middle of a fetch, at row 7.
    start_frame(4'd2, 4'd2);
    for (int r = 0; r < 7; r++) begin
      wait_req();
      mem_if.mem_ack = 1'b1;
      @(negedge clk);
      mem_if.mem_ack = 1'b0;
    end
    wait_req();
    chk("row7_addr", 128'(mem_if.mem_row), 128'd4);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy",    128'(busy),           128'd0);
    chk("midrst_mem_req", 128'(mem_if.mem_req), 128'd0);
    chk("midrst_vld",     128'(core_row_vld),   128'd0);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("no_resume", 128'({busy, mem_if.mem_req}), 128'd0);
    end

    for (int k = 0; k < 11; k++) begin
      if (vecs[k].bx == 4'd0 && vecs[k].by == 4'd0) start_frame(vecs[k].w, vecs[k].h);
      run_block(vecs[k]);
    end

    repeat (2) @(negedge clk);
    chk("idle_end", 128'({busy, mem_if.mem_req, blk_vld}), 128'd0);
    chk("core_start_total", 128'(cs_cnt), 128'd12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
